// File: rtl/kv_cache_pkg.sv
// Shared types and address helper for the multi-head K/V cache.
// Physical layout: one DEPTH-sized ring per head, stacked by head index.
package kv_cache_pkg;

   typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

   function automatic logic [31:0] phys_addr(
      input logic [31:0] head,
      input logic [31:0] base,
      input logic [31:0] logical,
      input int unsigned aw
   );
      logic [31:0] mask;
      mask = (32'd1 << aw) - 32'd1;
      return (head << aw) | ((base + logical) & mask);
   endfunction

endpackage

// File: rtl/kv_rd_skid.sv
// Two-entry skid buffer with registered output for the read stream.
// The spare entry catches a beat already in flight when the consumer stalls.
module kv_rd_skid
   import kv_cache_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             in_fire;

   assign in_ready = !skid_valid;
   assign in_fire  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_fire;
            if (in_fire) out_data <= in_data;
         end
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/kv_cache_mh.sv
// Multi-head append-only K/V cache with optional ring mode and
// streamed (head, start, count) reads over valid/ready.
module kv_cache_mh
   import kv_cache_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 256,
   parameter  int NUM_HEADS  = 4,
   parameter  int WRAP_EN    = 0,
   localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          app_valid,
   output logic                          app_ready,
   input  logic [HW-1:0]                 app_head,
   input  logic [DATA_WIDTH-1:0]         app_k,
   input  logic [DATA_WIDTH-1:0]         app_v,
   input  logic                          clr_valid,
   input  logic [HW-1:0]                 clr_head,
   input  logic                          rd_req_valid,
   output logic                          rd_req_ready,
   input  logic [HW-1:0]                 rd_req_head,
   input  logic [AW-1:0]                 rd_req_start,
   input  logic [AW:0]                   rd_req_count,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [DATA_WIDTH-1:0]         rd_k,
   output logic [DATA_WIDTH-1:0]         rd_v,
   output logic [AW-1:0]                 rd_idx,
   output logic                          rd_last,
   output logic [NUM_HEADS*(AW+1)-1:0]   seq_len,
   output logic                          err_range
);

   localparam int LW  = AW + 1;
   localparam int PAW = HW + AW;
   localparam int MW  = 2 * DATA_WIDTH;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [HW:0]   NH   = (HW + 1)'(NUM_HEADS);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] k;
      logic [DATA_WIDTH-1:0] v;
      logic [AW-1:0]         idx;
      logic                  last;
   } kv_beat_t;

   logic [LW-1:0] len  [NUM_HEADS];
   logic [AW-1:0] base [NUM_HEADS];
   logic [MW-1:0] mem  [NUM_HEADS*DEPTH];

   logic           app_ok, app_fire;
   logic [LW-1:0]  app_len;
   logic [AW-1:0]  app_base;
   logic [PAW-1:0] waddr;

   assign app_ok    = {1'b0, app_head} < NH;
   assign app_len   = app_ok ? len[app_head] : '0;
   assign app_base  = app_ok ? base[app_head] : '0;
   assign app_ready = !rst && app_ok
                    && !(clr_valid && clr_head == app_head)
                    && (WRAP_EN != 0 || app_len != FULL);
   assign app_fire  = app_valid && app_ready;
   // A full ring writes logical DEPTH, i.e. the oldest slot at base.
   assign waddr = PAW'(phys_addr(32'(app_head), 32'(app_base),
                                 32'(app_len), AW));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int h = 0; h < NUM_HEADS; h++) begin
            len[h]  <= '0;
            base[h] <= '0;
         end
      end else begin
         for (int h = 0; h < NUM_HEADS; h++) begin
            if (clr_valid && clr_head == HW'(h)) begin
               len[h]  <= '0;
               base[h] <= '0;
            end else if (app_fire && app_head == HW'(h)) begin
               if (len[h] != FULL) len[h] <= len[h] + LW'(1);
               else base[h] <= base[h] + AW'(1);
            end
         end
      end
   end

   always_comb begin
      seq_len = '0;
      for (int h = 0; h < NUM_HEADS; h++)
         seq_len[h*LW +: LW] = len[h];
   end

   rd_state_e      state;
   logic [HW-1:0]  s_head;
   logic [AW-1:0]  s_base, s_idx;
   logic [LW-1:0]  s_left;
   logic           pend, pend_last;
   logic [AW-1:0]  pend_idx;
   logic [MW-1:0]  rdata;
   logic           skid_ready, pend_fire, issue;
   logic           req_head_ok, req_bad;
   logic [LW-1:0]  req_len;
   logic [AW+1:0]  req_end;
   logic [PAW-1:0] raddr;
   kv_beat_t       in_beat, out_beat;

   assign rd_req_ready = !rst && state == RD_IDLE;
   assign req_head_ok  = {1'b0, rd_req_head} < NH;
   assign req_len      = req_head_ok ? len[rd_req_head] : '0;
   assign req_end      = (AW+2)'(rd_req_start) + (AW+2)'(rd_req_count);
   assign req_bad      = rd_req_count == '0 || !req_head_ok
                       || req_end > (AW+2)'(req_len);

   // The read register only advances when its beat can move on.
   assign pend_fire = pend && skid_ready;
   assign issue     = state == RD_STREAM && s_left != '0
                    && (!pend || pend_fire);
   assign raddr     = PAW'(phys_addr(32'(s_head), 32'(s_base),
                                     32'(s_idx), AW));
   assign in_beat   = {rdata, pend_idx, pend_last};

   always_ff @(posedge clk) begin
      if (app_fire) mem[waddr] <= {app_k, app_v};
      if (issue)
         rdata <= (app_fire && waddr == raddr) ? {app_k, app_v}
                                               : mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RD_IDLE;
         err_range <= 1'b0;
         s_head    <= '0;
         s_base    <= '0;
         s_idx     <= '0;
         s_left    <= '0;
         pend      <= 1'b0;
         pend_idx  <= '0;
         pend_last <= 1'b0;
      end else begin
         err_range <= 1'b0;
         if (pend_fire) pend <= 1'b0;
         if (issue) begin
            pend      <= 1'b1;
            pend_idx  <= s_idx;
            pend_last <= s_left == LW'(1);
            s_idx     <= s_idx + AW'(1);
            s_left    <= s_left - LW'(1);
         end
         unique case (state)
            RD_IDLE: begin
               if (rd_req_valid) begin
                  if (req_bad) begin
                     err_range <= 1'b1;
                  end else begin
                     s_head <= rd_req_head;
                     s_base <= base[rd_req_head];
                     s_idx  <= rd_req_start;
                     s_left <= rd_req_count;
                     state  <= RD_STREAM;
                  end
               end
            end
            RD_STREAM: begin
               if (rd_valid && rd_ready && rd_last) state <= RD_IDLE;
            end
            default: state <= RD_IDLE;
         endcase
      end
   end

   kv_rd_skid #(.WIDTH($bits(kv_beat_t))) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pend),
      .in_ready  (skid_ready),
      .in_data   (in_beat),
      .out_valid (rd_valid),
      .out_ready (rd_ready),
      .out_data  (out_beat)
   );

   assign rd_k    = out_beat.k;
   assign rd_v    = out_beat.v;
   assign rd_idx  = out_beat.idx;
   assign rd_last = out_beat.last;

endmodule
